// File: rtl/add_resp_checker.sv
// Response checker for the W-bit operand adder: predicts each sum, queues it in order,
// and scores returned results against the oldest prediction with counters and sticky flags.
module add_resp_checker #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    output logic                       in_ready,
    input  logic                       res_valid,
    input  logic [W:0]                 res_c,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       err_pulse,
    output logic                       mismatch_flag,
    output logic [W:0]                 first_bad_exp,
    output logic [W:0]                 first_bad_got,
    output logic                       proto_err,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t          state_q;
    logic [W:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   count;

    logic            active;
    logic            push;
    logic            pop;
    logic            proto_hit;
    logic            match;
    logic [W:0]      exp_sum;
    logic [PW-1:0]   count_next;

    assign state    = state_q;
    assign pending  = count;
    // Derived from the registered count only, so a same-cycle pop never reopens a full FIFO.
    assign in_ready = (count != PW'(DEPTH));

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        active     = (state_q != ERR);
        push       = active && in_valid && in_ready;
        pop        = active && res_valid && (count != '0);
        proto_hit  = active && ((in_valid && !in_ready) || (res_valid && (count == '0)));
        match      = (res_c == mem[rd_ptr]);
        exp_sum    = {1'b0, in_a} + {1'b0, in_b};
        count_next = count + PW'(push) - PW'(pop);
    end

    // NOTE: the expectation storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= exp_sum;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            err_pulse     <= 1'b0;
            mismatch_flag <= 1'b0;
            first_bad_exp <= '0;
            first_bad_got <= '0;
            proto_err     <= 1'b0;
        end else if (clr) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            err_pulse     <= 1'b0;
            mismatch_flag <= 1'b0;
            first_bad_exp <= '0;
            first_bad_got <= '0;
            proto_err     <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            count     <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (match) begin
                    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                    err_pulse     <= 1'b1;
                    mismatch_flag <= 1'b1;
                    if (!mismatch_flag) begin
                        first_bad_exp <= mem[rd_ptr];
                        first_bad_got <= res_c;
                    end
                end
            end
            if (proto_hit) begin
                proto_err <= 1'b1;
                state_q   <= ERR;
            end else begin
                case (state_q)
                    IDLE:    if (count_next != '0) state_q <= BUSY;
                    BUSY:    if (count_next == '0) state_q <= IDLE;
                    default: state_q <= ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_add_resp_checker.sv
// Directed bench for add_resp_checker: a vector table for the basic traffic plus
// hand-written sequences for overflow, orphan results, clear, async reset and saturation.
module tb_add_resp_checker;

    localparam int W = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic         res_valid = 1'b0;
    logic [W:0]   res_c = '0;
    logic [2:0]   pending;
    logic [7:0]   pass_cnt;
    logic [7:0]   fail_cnt;
    logic         err_pulse;
    logic         mismatch_flag;
    logic [W:0]   first_bad_exp;
    logic [W:0]   first_bad_got;
    logic         proto_err;
    logic [1:0]   state;

    int errors = 0;
    int checks = 0;

    add_resp_checker #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .res_valid(res_valid), .res_c(res_c),
        .pending(pending), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_pulse(err_pulse), .mismatch_flag(mismatch_flag),
        .first_bad_exp(first_bad_exp), .first_bad_got(first_bad_got),
        .proto_err(proto_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [2:0] a;
        logic [2:0] b;
        logic       rv;
        logic [3:0] c;
        int         e_pending;
        int         e_pass;
        int         e_fail;
        int         e_state;
        int         e_pulse;
        int         e_ready;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply inputs for one rising edge, then release them; outputs are read 1 ns after the edge.
    task automatic cycle(input logic iv, input logic [2:0] a, input logic [2:0] b,
                         input logic rv, input logic [3:0] c);
        in_valid = iv; in_a = a; in_b = b; res_valid = rv; res_c = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0; res_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        //        iv a  b  rv c   pend pass fail st pulse rdy
        vecs[0]  = '{1, 0, 3, 0, 0,  1, 0, 0, 1, 0, 1};
        vecs[1]  = '{0, 0, 0, 1, 3,  0, 1, 0, 0, 0, 1};
        vecs[2]  = '{1, 2, 3, 0, 0,  1, 1, 0, 1, 0, 1};
        vecs[3]  = '{0, 0, 0, 1, 6,  0, 1, 1, 0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1};
        vecs[5]  = '{1, 2, 3, 0, 0,  1, 1, 1, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 4,  0, 1, 2, 0, 1, 1};
        vecs[7]  = '{1, 7, 7, 0, 0,  1, 1, 2, 1, 0, 1};
        vecs[8]  = '{1, 1, 1, 0, 0,  2, 1, 2, 1, 0, 1};
        vecs[9]  = '{1, 0, 0, 0, 0,  3, 1, 2, 1, 0, 1};
        vecs[10] = '{1, 3, 4, 0, 0,  4, 1, 2, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 14, 3, 2, 2, 1, 0, 1};
        vecs[12] = '{0, 0, 0, 1, 2,  2, 3, 2, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 1, 0,  1, 4, 2, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 1, 7,  0, 5, 2, 0, 0, 1};

        // Reset state
        #12;
        check("rst_pending", pending, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_ready", in_ready, 1);
        check("rst_state", state, 0);
        check("rst_proto", proto_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic match, mismatch, sticky first-bad capture, fill and drain
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].rv, vecs[i].c);
            check($sformatf("v%0d_pending", i), pending, vecs[i].e_pending);
            check($sformatf("v%0d_pass", i), pass_cnt, vecs[i].e_pass);
            check($sformatf("v%0d_fail", i), fail_cnt, vecs[i].e_fail);
            check($sformatf("v%0d_state", i), state, vecs[i].e_state);
            check($sformatf("v%0d_pulse", i), err_pulse, vecs[i].e_pulse);
            check($sformatf("v%0d_ready", i), in_ready, vecs[i].e_ready);
            if (i == 3) begin
                check("first_exp_a", first_bad_exp, 5);
                check("first_got_a", first_bad_got, 6);
            end
        end
        check("first_exp_b", first_bad_exp, 5);
        check("first_got_b", first_bad_got, 6);
        check("mismatch_flag", mismatch_flag, 1);
        check("proto_clean", proto_err, 0);

        // Refill, then push into a full FIFO
        for (int i = 0; i < 4; i++) cycle(1, 3'(i), 3'd1, 0, 0);
        check("full_pending", pending, 4);
        check("full_ready", in_ready, 0);
        cycle(1, 1, 1, 0, 0);
        check("ovf_proto", proto_err, 1);
        check("ovf_state", state, 2);
        check("ovf_pending", pending, 4);
        cycle(0, 0, 0, 1, 1);
        check("err_frozen_pending", pending, 4);
        check("err_frozen_pass", pass_cnt, 5);
        check("err_frozen_fail", fail_cnt, 2);
        pulse_clr();
        check("clr1_state", state, 0);
        check("clr1_pending", pending, 0);

        // Orphan result from IDLE, pushes ignored in ERR, then clear
        cycle(0, 0, 0, 1, 0);
        check("orph_proto", proto_err, 1);
        check("orph_state", state, 2);
        cycle(1, 2, 2, 0, 0);
        check("err_push_ignored", pending, 0);
        pulse_clr();
        check("clr2_state", state, 0);
        check("clr2_pass", pass_cnt, 0);
        check("clr2_fail", fail_cnt, 0);
        check("clr2_mflag", mismatch_flag, 0);
        check("clr2_proto", proto_err, 0);
        check("clr2_ready", in_ready, 1);
        check("clr2_first_exp", first_bad_exp, 0);

        // Result together with a push into an empty FIFO is still an orphan
        cycle(1, 1, 2, 1, 3);
        check("sameclk_proto", proto_err, 1);
        check("sameclk_state", state, 2);
        check("sameclk_pass", pass_cnt, 0);
        pulse_clr();

        // Asynchronous reset between edges
        cycle(1, 1, 1, 0, 0);
        cycle(1, 2, 2, 0, 0);
        check("pre_rst_pending", pending, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_pending", pending, 0);
        check("async_state", state, 0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: 255 matches, then one more
        cycle(1, 3, 2, 0, 0);
        for (int i = 0; i < 254; i++) begin
            cycle(1, 3, 2, 1, 5);
            if (i == 0) check("pushpop_pending", pending, 1);
        end
        cycle(0, 0, 0, 1, 5);
        check("sat_pass_255", pass_cnt, 255);
        check("sat_pending", pending, 0);
        cycle(1, 4, 4, 0, 0);
        cycle(0, 0, 0, 1, 8);
        check("sat_pass_hold", pass_cnt, 255);
        check("sat_fail", fail_cnt, 0);
        check("sat_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
